// File: rtl/psychic5_video_pkg.sv
// Shared video-timing definitions: adjust-mode encoding and the VPOS_ADJ decode.
`default_nettype none

package psychic5_video_pkg;

  typedef enum logic [1:0] {
    MODE_ORIG     = 2'd0,
    MODE_NTSC     = 2'd1,
    MODE_CUSTOM   = 2'd2,
    MODE_ORIG_ALT = 2'd3
  } pxcntr_mode_e;

  localparam int VOFF_W = 5;

  // Collapse the alternate encoding onto ORIG so both compare as the same mode.
  function automatic pxcntr_mode_e mode_class(input logic [1:0] mode);
    pxcntr_mode_e m;
    case (mode)
      2'd1:    m = MODE_NTSC;
      2'd2:    m = MODE_CUSTOM;
      default: m = MODE_ORIG;
    endcase
    return m;
  endfunction

  // 0 and 8 mean no shift; 1..7 move VSYNC up 7..1 lines, 9..15 move it down 1..7.
  function automatic logic signed [VOFF_W-1:0] vpos_adj_offset(input logic [3:0] adj);
    logic signed [VOFF_W-1:0] off;
    if (adj == 4'd0) off = '0;
    else             off = $signed({1'b0, adj}) - 5'sd8;
    return off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pxcntr_timing_gen_if.sv
// Pixel-clock-enable strobe shared between the prescaler and its consumers.
`default_nettype none

interface pxcntr_timing_gen_if;
  logic pxcen;

  modport master (output pxcen);
  modport slave  (input  pxcen);
endinterface

`default_nettype wire

// File: rtl/pxcntr_timing_gen_pxcen_gen.sv
// Master-clock prescaler: one-clock pixel enable every CLK_DIV clocks.
`default_nettype none

module pxcen_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  pxcntr_timing_gen_if.master        px_if
);

  localparam int                PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]     C_LAST  = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = (presc_q == C_LAST) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) presc_q <= '0;
    else         presc_q <= presc_d;
  end

  assign px_if.pxcen = (presc_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/pxcntr_timing_gen.sv
// Pixel/line counter with frame-latched timing mode, VSYNC offset and screen flip.
`default_nettype none

module pxcntr_timing_gen
  import psychic5_video_pkg::*;
#(
  parameter int CLK_DIV      = 10,
  parameter int HW           = 9,
  parameter int VW           = 9,
  parameter int H_TOTAL      = 384,
  parameter int H_ACTIVE     = 256,
  parameter int HS_START     = 288,
  parameter int HS_LEN       = 32,
  parameter int V_TOTAL      = 264,
  parameter int V_ACTIVE     = 224,
  parameter int VS_START     = 240,
  parameter int VS_LEN       = 8,
  parameter int NTSC_H_TOTAL = 384,
  parameter int NTSC_V_TOTAL = 262
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_RST_n,
  input  logic [1:0]    i_EMU_PXCNTR_ADJ_MODE,
  input  logic [1:0]    i_EMU_PXCNTR_ADJ_H,
  input  logic [2:0]    i_EMU_PXCNTR_ADJ_V,
  input  logic [3:0]    i_EMU_VPOS_ADJ,
  input  logic          i_EMU_FLIP,
  output logic          o_PXCEN,
  output logic [HW-1:0] o_HCNT,
  output logic [VW-1:0] o_VCNT,
  output logic          o_HBLANK_n,
  output logic          o_VBLANK_n,
  output logic          o_HSYNC_n,
  output logic          o_VSYNC_n,
  output logic          o_FLIP,
  output logic          o_FRAME_START,
  output logic          o_NEW_VMODE
);

  localparam int HX = HW + 1;
  localparam int VX = VW + 1;
  localparam int SX = VX + 2;

  if (CLK_DIV < 2) begin : g_chk_clk_div
    $error("pxcntr_timing_gen: CLK_DIV must be at least 2");
  end
  if (H_TOTAL + 6 >= 2**HW) begin : g_chk_hw
    $error("pxcntr_timing_gen: HW too narrow for H_TOTAL plus custom extension");
  end
  if (V_TOTAL + 7 >= 2**VW) begin : g_chk_vw
    $error("pxcntr_timing_gen: VW too narrow for V_TOTAL plus custom extension");
  end
  if (VS_START + 7 + VS_LEN > V_TOTAL) begin : g_chk_vs
    $error("pxcntr_timing_gen: shifted VSYNC does not fit in V_TOTAL");
  end

  pxcntr_timing_gen_if px_if ();

  pxcen_gen #(.CLK_DIV(CLK_DIV)) u_pxcen_gen (
    .clk_i  (i_EMU_MCLK),
    .rst_ni (i_EMU_RST_n),
    .px_if  (px_if.master)
  );

  logic                     pxcen;
  logic [HW-1:0]            hcnt_q, hcnt_d;
  logic [VW-1:0]            vcnt_q, vcnt_d;
  logic [HX-1:0]            htot_q, htot_d;
  logic [VX-1:0]            vtot_q, vtot_d;
  logic signed [VOFF_W-1:0] voff_q, voff_d;
  logic                     flip_q, flip_d;
  pxcntr_mode_e             mode_q, mode_d;
  logic                     h_last, v_last, boundary;

  assign pxcen    = px_if.pxcen;
  assign h_last   = ({1'b0, hcnt_q} == htot_q - HX'(1));
  assign v_last   = ({1'b0, vcnt_q} == vtot_q - VX'(1));
  assign boundary = pxcen & h_last & v_last;

  // Timing settings are sampled only at the frame boundary so a frame never tears.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    htot_d = htot_q;
    vtot_d = vtot_q;
    voff_d = voff_q;
    flip_d = flip_q;
    mode_d = mode_q;
    if (pxcen) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
    if (boundary) begin
      mode_d = mode_class(i_EMU_PXCNTR_ADJ_MODE);
      case (mode_d)
        MODE_NTSC: begin
          htot_d = HX'(NTSC_H_TOTAL);
          vtot_d = VX'(NTSC_V_TOTAL);
        end
        MODE_CUSTOM: begin
          htot_d = HX'(H_TOTAL) + HX'({i_EMU_PXCNTR_ADJ_H, 1'b0});
          vtot_d = VX'(V_TOTAL) + VX'(i_EMU_PXCNTR_ADJ_V);
        end
        default: begin
          htot_d = HX'(H_TOTAL);
          vtot_d = VX'(V_TOTAL);
        end
      endcase
      voff_d = vpos_adj_offset(i_EMU_VPOS_ADJ);
      flip_d = i_EMU_FLIP;
    end
  end

  // VSYNC start is shifted, then kept out of the active area and inside the frame.
  logic signed [SX-1:0] vs_raw, vs_lo, vs_hi, vs_start, vs_end, vpos_next;

  always_comb begin
    vs_raw    = SX'(VS_START) + SX'(voff_q);
    vs_lo     = SX'(V_ACTIVE);
    vs_hi     = $signed({2'b00, vtot_q}) - SX'(VS_LEN);
    if (vs_raw < vs_lo)      vs_start = vs_lo;
    else if (vs_raw > vs_hi) vs_start = vs_hi;
    else                     vs_start = vs_raw;
    vs_end    = vs_start + SX'(VS_LEN);
    vpos_next = $signed({3'b000, vcnt_d});
  end

  logic [HW-1:0] hcnt_out_q;
  logic [VW-1:0] vcnt_out_q;
  logic          hblank_n_q, vblank_n_q, hsync_n_q, vsync_n_q;
  logic          frame_start_q, new_vmode_q;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
    if (!i_EMU_RST_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      htot_q        <= HX'(H_TOTAL);
      vtot_q        <= VX'(V_TOTAL);
      voff_q        <= '0;
      flip_q        <= 1'b0;
      mode_q        <= MODE_ORIG;
      hcnt_out_q    <= '0;
      vcnt_out_q    <= '0;
      hblank_n_q    <= 1'b1;
      vblank_n_q    <= 1'b1;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
      new_vmode_q   <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      htot_q        <= htot_d;
      vtot_q        <= vtot_d;
      voff_q        <= voff_d;
      flip_q        <= flip_d;
      mode_q        <= mode_d;
      frame_start_q <= boundary;
      if (boundary && (mode_d != mode_q)) new_vmode_q <= ~new_vmode_q;
      if (pxcen) begin
        hcnt_out_q <= flip_d ? ~hcnt_d : hcnt_d;
        vcnt_out_q <= flip_d ? ~vcnt_d : vcnt_d;
        hblank_n_q <= ({1'b0, hcnt_d} < HX'(H_ACTIVE));
        vblank_n_q <= ({1'b0, vcnt_d} < VX'(V_ACTIVE));
        hsync_n_q  <= !(({1'b0, hcnt_d} >= HX'(HS_START)) &&
                        ({1'b0, hcnt_d} <  HX'(HS_START + HS_LEN)));
        vsync_n_q  <= !((vpos_next >= vs_start) && (vpos_next < vs_end));
      end
    end
  end

  assign o_PXCEN       = pxcen;
  assign o_HCNT        = hcnt_out_q;
  assign o_VCNT        = vcnt_out_q;
  assign o_HBLANK_n    = hblank_n_q;
  assign o_VBLANK_n    = vblank_n_q;
  assign o_HSYNC_n     = hsync_n_q;
  assign o_VSYNC_n     = vsync_n_q;
  assign o_FLIP        = flip_q;
  assign o_FRAME_START = frame_start_q;
  assign o_NEW_VMODE   = new_vmode_q;

endmodule

`default_nettype wire

// File: tb/tb_pxcntr_timing_gen.sv
// Bench for pxcntr_timing_gen: frame-level reference model plus directed timing checks.
`default_nettype none

module tb_pxcntr_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int HW = 6, VW = 6;
  localparam int H_TOTAL = 24, H_ACTIVE = 16, HS_START = 18, HS_LEN = 3;
  localparam int V_TOTAL = 30, V_ACTIVE = 14, VS_START = 18, VS_LEN = 3;
  localparam int NTSC_H_TOTAL = 22, NTSC_V_TOTAL = 26;
  localparam int HMASK = (1 << HW) - 1;
  localparam int VMASK = (1 << VW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode, adjh;
  logic [2:0]    adjv;
  logic [3:0]    vpos;
  logic          flip;
  logic          o_PXCEN, o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n;
  logic          o_FLIP, o_FRAME_START, o_NEW_VMODE;
  logic [HW-1:0] o_HCNT;
  logic [VW-1:0] o_VCNT;

  always #5 clk = ~clk;

  pxcntr_timing_gen_if mon_if ();
  assign mon_if.pxcen = o_PXCEN;

  pxcntr_timing_gen #(
    .CLK_DIV(CLK_DIV), .HW(HW), .VW(VW),
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .HS_START(HS_START), .HS_LEN(HS_LEN),
    .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_LEN(VS_LEN),
    .NTSC_H_TOTAL(NTSC_H_TOTAL), .NTSC_V_TOTAL(NTSC_V_TOTAL)
  ) dut (
    .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n),
    .i_EMU_PXCNTR_ADJ_MODE(mode), .i_EMU_PXCNTR_ADJ_H(adjh),
    .i_EMU_PXCNTR_ADJ_V(adjv), .i_EMU_VPOS_ADJ(vpos), .i_EMU_FLIP(flip),
    .o_PXCEN(o_PXCEN), .o_HCNT(o_HCNT), .o_VCNT(o_VCNT),
    .o_HBLANK_n(o_HBLANK_n), .o_VBLANK_n(o_VBLANK_n),
    .o_HSYNC_n(o_HSYNC_n), .o_VSYNC_n(o_VSYNC_n), .o_FLIP(o_FLIP),
    .o_FRAME_START(o_FRAME_START), .o_NEW_VMODE(o_NEW_VMODE)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      if (n_fail >= 40) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  endtask

  // Reference model: position within the frame and the settings latched for it.
  int m_n, m_h, m_v, m_ht, m_vt, m_off, m_mode, m_flip;
  int e_hcnt, e_vcnt;
  bit e_pxcen, e_hb, e_vb, e_hs, e_vs, e_fs, e_nvm;

  always @(posedge clk or negedge rst_n) begin : p_model
    bit pix, bnd;
    int md, s;
    if (!rst_n) begin
      m_n = 0; m_h = 0; m_v = 0; m_ht = H_TOTAL; m_vt = V_TOTAL;
      m_off = 0; m_mode = 0; m_flip = 0;
      e_pxcen = 0; e_hcnt = 0; e_vcnt = 0;
      e_hb = 1; e_vb = 1; e_hs = 1; e_vs = 1; e_fs = 0; e_nvm = 0;
    end else begin
      pix = ((m_n % CLK_DIV) == CLK_DIV - 1);
      m_n++;
      e_pxcen = ((m_n % CLK_DIV) == CLK_DIV - 1);
      e_fs = 0;
      if (pix) begin
        bnd = (m_h == m_ht - 1) && (m_v == m_vt - 1);
        m_h++;
        if (m_h == m_ht) begin
          m_h = 0;
          m_v++;
          if (m_v == m_vt) m_v = 0;
        end
        if (bnd) begin
          md = (int'(mode) == 3) ? 0 : int'(mode);
          if (md == 1) begin m_ht = NTSC_H_TOTAL; m_vt = NTSC_V_TOTAL; end
          else if (md == 2) begin m_ht = H_TOTAL + 2 * int'(adjh); m_vt = V_TOTAL + int'(adjv); end
          else begin m_ht = H_TOTAL; m_vt = V_TOTAL; end
          if (md != m_mode) e_nvm = !e_nvm;
          m_mode = md;
          m_off  = (vpos == 4'd0) ? 0 : int'(vpos) - 8;
          m_flip = int'(flip);
          e_fs   = 1;
        end
        s = VS_START + m_off;
        if (s < V_ACTIVE) s = V_ACTIVE;
        if (s > m_vt - VS_LEN) s = m_vt - VS_LEN;
        e_hcnt = (m_flip != 0) ? (~m_h & HMASK) : m_h;
        e_vcnt = (m_flip != 0) ? (~m_v & VMASK) : m_v;
        e_hb = (m_h < H_ACTIVE);
        e_vb = (m_v < V_ACTIVE);
        e_hs = !((m_h >= HS_START) && (m_h < HS_START + HS_LEN));
        e_vs = !((m_v >= s) && (m_v < s + VS_LEN));
      end
    end
  end

  // Per-frame observations used by the directed checks.
  int clk_cnt = 0, fs_clk = 0, last_len = 0, fs_count = 0;
  int vs_min = 1000, vs_max = -1, last_vs_min = 0, last_vs_max = 0;
  int fs_hcnt = 0, fs_flip = 0, nvm_tog = 0;
  logic prev_nvm = 1'b0;

  always @(posedge clk) begin : p_compare
    #1;
    if (rst_n) begin
      chk("pxcen",       int'(mon_if.pxcen),   int'(e_pxcen));
      chk("hcnt",        int'(o_HCNT),         e_hcnt);
      chk("vcnt",        int'(o_VCNT),         e_vcnt);
      chk("hblank_n",    int'(o_HBLANK_n),     int'(e_hb));
      chk("vblank_n",    int'(o_VBLANK_n),     int'(e_vb));
      chk("hsync_n",     int'(o_HSYNC_n),      int'(e_hs));
      chk("vsync_n",     int'(o_VSYNC_n),      int'(e_vs));
      chk("flip",        int'(o_FLIP),         m_flip);
      chk("frame_start", int'(o_FRAME_START),  int'(e_fs));
      chk("new_vmode",   int'(o_NEW_VMODE),    int'(e_nvm));
      clk_cnt++;
      if (o_NEW_VMODE != prev_nvm) nvm_tog++;
      prev_nvm = o_NEW_VMODE;
      if (o_FRAME_START) begin
        last_len    = clk_cnt - fs_clk;
        fs_clk      = clk_cnt;
        last_vs_min = vs_min;
        last_vs_max = vs_max;
        vs_min = 1000; vs_max = -1;
        fs_hcnt = int'(o_HCNT);
        fs_flip = int'(o_FLIP);
        fs_count++;
      end
      if (!o_VSYNC_n) begin
        if (int'(o_VCNT) < vs_min) vs_min = int'(o_VCNT);
        if (int'(o_VCNT) > vs_max) vs_max = int'(o_VCNT);
      end
    end else begin
      prev_nvm = o_NEW_VMODE;
    end
  end

  task automatic wait_fs();
    int c0;
    c0 = fs_count;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (fs_count != c0) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_fs: no frame start within 5000 clocks, got none, expected one");
  endtask

  task automatic wait_vcnt(input int v);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (int'(o_VCNT) == v) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_vcnt: line %0d not reached, got %0d, expected %0d", v, o_VCNT, v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pxcen"},  int'(o_PXCEN), 0);
    chk({tag, "_hcnt"},   int'(o_HCNT), 0);
    chk({tag, "_vcnt"},   int'(o_VCNT), 0);
    chk({tag, "_sync_n"}, int'({o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n}), 15);
    chk({tag, "_flags"},  int'({o_FLIP, o_FRAME_START, o_NEW_VMODE}), 0);
  endtask

  task automatic run_vs(input int md, input int vp, input int len, input int lo, input int hi);
    @(negedge clk);
    mode = 2'(md); vpos = 4'(vp);
    wait_fs(); wait_fs();
    chk("vs_frame_len", last_len, len);
    chk("vs_first_line", last_vs_min, lo);
    chk("vs_last_line",  last_vs_max, hi);
  endtask

  initial begin : p_watchdog
    #900000;
    n_chk++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : p_stim
    int base;
    rst_n = 1'b0; mode = 2'd0; adjh = 2'd0; adjv = 3'd0; vpos = 4'd8; flip = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;

    wait_fs(); wait_fs();
    chk("mode0_frame_len", last_len, H_TOTAL * V_TOTAL * CLK_DIV);
    chk("mode0_vs_first", last_vs_min, 18);
    chk("mode0_vs_last",  last_vs_max, 20);

    // Custom timing requested mid-frame; the running frame keeps the old totals.
    repeat (300) @(negedge clk);
    base = nvm_tog;
    mode = 2'd2; adjh = 2'd3; adjv = 3'd7;
    wait_fs();
    chk("custom_cur_frame_len", last_len, 1440);
    wait_fs();
    chk("custom_frame_len", last_len, 2220);
    chk("custom_model_htot", m_ht, 30);
    chk("custom_model_vtot", m_vt, 37);
    chk("custom_nvm_toggles", nvm_tog - base, 1);

    run_vs(0, 1,  1440, 14, 16);
    run_vs(0, 15, 1440, 25, 27);
    run_vs(0, 0,  1440, 18, 20);
    run_vs(0, 8,  1440, 18, 20);
    run_vs(1, 15, 1144, 23, 25);
    run_vs(0, 8,  1440, 18, 20);

    base = nvm_tog;
    mode = 2'd3;
    wait_fs(); wait_fs();
    chk("mode3_nvm_toggles", nvm_tog - base, 0);
    chk("mode3_frame_len", last_len, 1440);

    wait_vcnt(20);
    flip = 1'b1;
    wait_fs();
    chk("flip_fs_hcnt", fs_hcnt, HMASK);
    chk("flip_fs_flag", fs_flip, 1);

    // Asynchronous reset in the middle of a flipped frame.
    mode = 2'd1;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_fs(); wait_fs();
    chk("post_rst_frame_len", last_len, 1144);

    flip = 1'b0;
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(1500, 50)) @(negedge clk);
      mode = 2'($urandom_range(3, 0));
      adjh = 2'($urandom_range(3, 0));
      adjv = 3'($urandom_range(7, 0));
      vpos = 4'($urandom_range(15, 0));
      flip = 1'($urandom_range(1, 0));
    end
    wait_fs(); wait_fs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pxcntr_timing_gen.md
PXCNTR_TIMING_GEN -- requirements
Module: pxcntr_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10, meaning master clocks per pixel (60 MHz to 6 MHz).
REQ-002 SHALL have parameter HW, default 9, meaning horizontal counter width.
REQ-003 SHALL have parameter VW, default 9, meaning vertical counter width.
REQ-004 SHALL have parameters H_TOTAL 384, H_ACTIVE 256, HS_START 288, HS_LEN 32, meaning original horizontal timing in pixels.
REQ-005 SHALL have parameters V_TOTAL 264, V_ACTIVE 224, VS_START 240, VS_LEN 8, meaning original vertical timing in lines.
REQ-006 SHALL have parameters NTSC_H_TOTAL 384 and NTSC_V_TOTAL 262, meaning NTSC-friendly totals.
REQ-007 SHALL have port i_EMU_MCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port i_EMU_RST_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port i_EMU_PXCNTR_ADJ_MODE, input, 2 bits: 0 original, 1 NTSC-friendly, 2 custom, 3 treated as original.
REQ-010 SHALL have port i_EMU_PXCNTR_ADJ_H, input, 2 bits: custom extra pixels/2 per line.
REQ-011 SHALL have port i_EMU_PXCNTR_ADJ_V, input, 3 bits: custom extra lines per frame.
REQ-012 SHALL have port i_EMU_VPOS_ADJ, input, 4 bits: 0 original, 1..7 = -7..-1, 8 = 0, 9..15 = +1..+7 line VSYNC offset.
REQ-013 SHALL have port i_EMU_FLIP, input, 1 bit: screen flip request.
REQ-014 SHALL have outputs o_PXCEN (1), o_HCNT (HW), o_VCNT (VW), o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n, o_FLIP, o_FRAME_START (1 each), o_NEW_VMODE (1, toggle).

Function
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and assert o_PXCEN for exactly one clock when it equals CLK_DIV-1.
REQ-016 Internal hcnt SHALL advance on o_PXCEN and wrap from h_total_eff-1 to 0; vcnt SHALL advance on hcnt wrap and wrap from v_total_eff-1 to 0.
REQ-017 Frame boundary SHALL be o_PXCEN with hcnt = h_total_eff-1 and vcnt = v_total_eff-1.
REQ-018 At frame boundary only SHALL latch: h_total_eff/v_total_eff (mode 0/3: H_TOTAL/V_TOTAL; 1: NTSC totals; 2: H_TOTAL+2*ADJ_H, V_TOTAL+ADJ_V), vsync offset and flip; mid-frame input changes SHALL NOT alter the current frame.
REQ-019 o_NEW_VMODE SHALL toggle on the boundary where the latched mode differs from the previous latched mode (3 and 0 count as equal).
REQ-020 o_FRAME_START SHALL pulse one clock, the clock after the boundary.
REQ-021 All video outputs SHALL be registered, updated the clock after o_PXCEN, decoding the new counter values: HBLANK_n = hcnt<H_ACTIVE; VBLANK_n = vcnt<V_ACTIVE; HSYNC_n low for HS_START<=hcnt<HS_START+HS_LEN; VSYNC_n low for VS_START+off<=vcnt<VS_START+off+VS_LEN.
REQ-022 Offset start SHALL be clamped into [V_ACTIVE, v_total_eff-VS_LEN].
REQ-023 o_HCNT/o_VCNT SHALL be bitwise-inverted counters when latched flip=1, else true counters; o_FLIP SHALL show latched flip.
REQ-024 Sum arithmetic SHALL be performed at HW+1/VW+1 bits; no wrap of totals.

Reset
REQ-025 On i_EMU_RST_n low: prescaler, hcnt, vcnt = 0; totals = original; offset 0; flip 0; o_PXCEN, o_FRAME_START, o_NEW_VMODE = 0; all *_n outputs = 1; o_HCNT/o_VCNT = 0.
REQ-026 Reset mid-frame SHALL restart at hcnt=vcnt=0 original mode with no o_NEW_VMODE toggle on release.

Structure
REQ-027 Mode encoding constants and the VPOS_ADJ-to-signed-offset decode function SHALL live in shared package psychic5_video_pkg.
REQ-028 Prescaler SHALL be sub-module pxcen_gen (parameter CLK_DIV); the rest is flat.
REQ-029 Elaboration SHALL fail if H_TOTAL+6 >= 2**HW, V_TOTAL+7 >= 2**VW, or VS_START+7+VS_LEN > V_TOTAL.

Verification
REQ-030 Defaults, mode 0: o_PXCEN period 10 clocks; frame = 1,013,760 clocks; o_HSYNC_n low 32 px from hcnt 288.
REQ-031 Mode 2, ADJ_H=3, ADJ_V=7 set mid-frame: current frame unchanged, next line 390 px, frame 271 lines, o_NEW_VMODE toggles once.
REQ-032 VPOS_ADJ 1 -> VSYNC_n low lines 233..240; 15 -> 247..254; 8 and 0 -> 240..247.
REQ-033 Mode 1 -> 262-line frames; switch 0->3 -> no o_NEW_VMODE toggle.
REQ-034 Flip set at vcnt 100 -> o_HCNT inverted from next frame start; o_FLIP rises with o_FRAME_START.
REQ-035 i_EMU_RST_n pulsed low at vcnt 150 -> outputs at reset values asynchronously; counting restarts from 0,0.
